// File: rtl/pwm_capture.sv
// Purpose : measures period and high time of an asynchronous PWM input, plus its direction line, as an Avalon-MM slave.
// Latency : input edge to committed register is 3 clk edges; register read data appears 1 cycle after the read strobe.
// Backpressure: none; slave is always ready (no waitrequest), and measurement runs regardless of bus activity.
//
// Ports:
//   clk, reset_n        system clock, asynchronous active-low reset
//   address/read/write  Avalon word address and strobes
//   writedata/readdata  Avalon data buses (readdata registered, fixed latency 1)
//   pwm_in, dir_in      asynchronous PWM and direction inputs
//
// Register map (word addresses):
//   0 PERIOD  RO  cycles between successive rising edges
//   1 HIGH    RO  cycles from rising to falling edge
//   2 STATUS  bit0 VALID (W1C), bit1 DIR (RO), bit2 TMO (W1C), bit3 OVF (W1C)
//   3 TIMEOUT RW  cycles without a completed period before TMO; 0 disables
module pwm_capture #(
   parameter int          CNT_W       = 32,
   parameter int unsigned DEF_TIMEOUT = 32'd50_000_000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  address,
   input  logic        read,
   input  logic        write,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   input  logic        pwm_in,
   input  logic        dir_in
);

   localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
   // Value one step below saturation: OVF is raised only on the step into
   // all-ones, so a W1C clear sticks while the counter sits saturated.
   localparam logic [CNT_W-1:0] CNT_PRE   = CNT_MAX - CNT_ONE;
   localparam logic [31:0]      DEF_TMO_W = DEF_TIMEOUT;
   localparam logic [CNT_W-1:0] TMO_RST   = DEF_TMO_W[CNT_W-1:0];

   localparam logic [1:0] ADDR_PERIOD  = 2'd0;
   localparam logic [1:0] ADDR_HIGH    = 2'd1;
   localparam logic [1:0] ADDR_STATUS  = 2'd2;
   localparam logic [1:0] ADDR_TIMEOUT = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HIGH = 2'd1,
      S_LOW  = 2'd2
   } state_t;

   state_t state_q, state_d;

   // Synchronizers; pwm_s3 is the previous synchronized value for edge detect.
   logic pwm_s1, pwm_s2, pwm_s3;
   logic dir_s1, dir_s2;
   logic rise, fall;

   logic [CNT_W-1:0] pcnt_q;
   logic [CNT_W-1:0] hpend_q;
   logic [CNT_W-1:0] period_q;
   logic [CNT_W-1:0] high_q;
   logic [CNT_W-1:0] timeout_q;
   logic             valid_q, dir_q, tmo_q, ovf_q;

   logic tmo_hit;
   logic commit, hcap, tmo_set, ovf_set;
   logic wr_status, wr_timeout;
   logic clr_valid, clr_tmo, clr_ovf;
   logic [31:0] rd_mux;

   assign rise = pwm_s2 & ~pwm_s3;
   assign fall = ~pwm_s2 & pwm_s3;

   // ------------------------------------------------------------------
   // Input synchronizers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pwm_s1 <= 1'b0;
         pwm_s2 <= 1'b0;
         pwm_s3 <= 1'b0;
         dir_s1 <= 1'b0;
         dir_s2 <= 1'b0;
      end else begin
         pwm_s1 <= pwm_in;
         pwm_s2 <= pwm_s1;
         pwm_s3 <= pwm_s2;
         dir_s1 <= dir_in;
         dir_s2 <= dir_s1;
      end
   end

   // ------------------------------------------------------------------
   // Cycle counter: restarts at 1 on each rise so that at the next edge it
   // holds the exact cycle distance from the last rise.
   // ------------------------------------------------------------------
   assign ovf_set = ~rise & (pcnt_q == CNT_PRE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pcnt_q <= '0;
      end else if (rise) begin
         pcnt_q <= CNT_ONE;
      end else if (pcnt_q != CNT_MAX) begin
         pcnt_q <= pcnt_q + CNT_ONE;
      end
   end

   // ------------------------------------------------------------------
   // Measurement FSM
   // ------------------------------------------------------------------
   assign tmo_hit = (timeout_q != '0) && (pcnt_q >= timeout_q);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Timeout takes priority over an edge in the same cycle: once the limit
   // is reached the current period is abandoned.
   always_comb begin
      state_d = state_q;
      commit  = 1'b0;
      hcap    = 1'b0;
      tmo_set = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (rise) begin
               state_d = S_HIGH;
            end
         end
         S_HIGH: begin
            if (tmo_hit) begin
               tmo_set = 1'b1;
               state_d = S_IDLE;
            end else if (fall) begin
               hcap    = 1'b1;
               state_d = S_LOW;
            end
         end
         S_LOW: begin
            if (tmo_hit) begin
               tmo_set = 1'b1;
               state_d = S_IDLE;
            end else if (rise) begin
               commit  = 1'b1;
               state_d = S_HIGH;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // High time is held pending until the period completes, so PERIOD and
   // HIGH always move together in a single cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hpend_q  <= '0;
         period_q <= '0;
         high_q   <= '0;
         dir_q    <= 1'b0;
      end else begin
         if (hcap) begin
            hpend_q <= pcnt_q;
         end
         if (commit) begin
            period_q <= pcnt_q;
            high_q   <= hpend_q;
            dir_q    <= dir_s2;
         end
      end
   end

   // ------------------------------------------------------------------
   // Register writes and status bits (hardware set wins over W1C)
   // ------------------------------------------------------------------
   assign wr_status  = write && (address == ADDR_STATUS);
   assign wr_timeout = write && (address == ADDR_TIMEOUT);
   assign clr_valid  = wr_status & writedata[0];
   assign clr_tmo    = wr_status & writedata[2];
   assign clr_ovf    = wr_status & writedata[3];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q   <= 1'b0;
         tmo_q     <= 1'b0;
         ovf_q     <= 1'b0;
         timeout_q <= TMO_RST;
      end else begin
         valid_q <= commit | (valid_q & ~clr_valid);
         ovf_q   <= ovf_set | (ovf_q & ~clr_ovf);
         if (tmo_set) begin
            tmo_q <= 1'b1;
         end else if (commit || clr_tmo) begin
            tmo_q <= 1'b0;
         end
         if (wr_timeout) begin
            timeout_q <= writedata[CNT_W-1:0];
         end
      end
   end

   // ------------------------------------------------------------------
   // Read path: registered, zero-extended, holds when read is low
   // ------------------------------------------------------------------
   always_comb begin
      rd_mux = '0;
      case (address)
         ADDR_PERIOD:  rd_mux[CNT_W-1:0] = period_q;
         ADDR_HIGH:    rd_mux[CNT_W-1:0] = high_q;
         ADDR_STATUS:  rd_mux[3:0]       = {ovf_q, tmo_q, dir_q, valid_q};
         ADDR_TIMEOUT: rd_mux[CNT_W-1:0] = timeout_q;
         default:      rd_mux            = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         readdata <= '0;
      end else if (read) begin
         readdata <= rd_mux;
      end
   end

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: a 32-bit instance for the main measurements and an
// 8-bit instance (TIMEOUT reset 0) for counter saturation and OVF.
module tb_pwm_capture;

   logic        clk;
   logic        reset_n;
   logic [1:0]  address;
   logic        read, write, read8, write8;
   logic [31:0] writedata;
   logic [31:0] readdata, readdata8;
   logic        pwm_in;
   logic        dir_in;

   int passed = 0;
   int total  = 0;

   pwm_capture dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .address   (address),
      .read      (read),
      .write     (write),
      .writedata (writedata),
      .readdata  (readdata),
      .pwm_in    (pwm_in),
      .dir_in    (dir_in)
   );

   pwm_capture #(.CNT_W(8), .DEF_TIMEOUT(0)) dut8 (
      .clk       (clk),
      .reset_n   (reset_n),
      .address   (address),
      .read      (read8),
      .write     (write8),
      .writedata (writedata),
      .readdata  (readdata8),
      .pwm_in    (pwm_in),
      .dir_in    (dir_in)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- PWM generator ----------------
   int gen_per   = 300;
   int gen_high  = 100;
   int gen_epoch = 0;
   bit gen_run   = 1'b0;
   bit gen_level = 1'b0;

   initial begin
      int cnt;
      int seen;
      cnt    = 0;
      seen   = 0;
      pwm_in = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (seen != gen_epoch) begin
            seen = gen_epoch;
            cnt  = 0;
         end
         if (gen_run) begin
            pwm_in = (cnt < gen_high);
            cnt    = (cnt + 1 >= gen_per) ? 0 : cnt + 1;
         end else begin
            pwm_in = gen_level;
         end
      end
   end

   task automatic start_gen(input int per, input int hi);
      gen_per   = per;
      gen_high  = hi;
      gen_epoch = gen_epoch + 1;
      gen_run   = 1'b1;
   endtask

   task automatic hold(input bit lvl);
      gen_run   = 1'b0;
      gen_level = lvl;
   endtask

   // ---------------- bus helpers ----------------
   task automatic bus_write(input bit sel8, input logic [1:0] a, input logic [31:0] d);
      @(posedge clk);
      #1;
      address   = a;
      writedata = d;
      if (sel8) write8 = 1'b1;
      else      write  = 1'b1;
      @(posedge clk);
      #1;
      write  = 1'b0;
      write8 = 1'b0;
   endtask

   task automatic bus_read(input bit sel8, input logic [1:0] a, output logic [31:0] d);
      @(posedge clk);
      #1;
      address = a;
      if (sel8) read8 = 1'b1;
      else      read  = 1'b1;
      @(posedge clk);
      #1;
      read  = 1'b0;
      read8 = 1'b0;
      d = sel8 ? readdata8 : readdata;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   // Returns at edge k + 3ns where pwm_in went high at edge k + 2ns.
   task automatic wait_pwm_rise();
      bit prev;
      bit seen;
      @(posedge clk);
      #3;
      prev = pwm_in;
      seen = 1'b0;
      for (int i = 0; i < 3000 && !seen; i++) begin
         @(posedge clk);
         #3;
         if (pwm_in && !prev) seen = 1'b1;
         prev = pwm_in;
      end
      if (!seen) begin
         total++;
         $display("FAIL pwm_rise_wait: no rising edge within 3000 cycles");
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      string       name;
      int          phase;
      bit          sel8;
      logic [1:0]  addr;
      logic [31:0] mask;
      logic [31:0] exp;
   } vec_t;

   vec_t vq[$];

   task automatic apply_phase(input int p);
      logic [31:0] d;
      foreach (vq[i]) begin
         if (vq[i].phase == p) begin
            bus_read(vq[i].sel8, vq[i].addr, d);
            check(vq[i].name, d & vq[i].mask, vq[i].exp);
         end
      end
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #500_000;
      total++;
      $display("FAIL watchdog: simulation did not complete in time");
      $display("%0d/%0d checks passed", passed, total);
      $fatal(1, "watchdog expired");
   end

   // ---------------- main sequence ----------------
   logic [31:0] rd;

   initial begin
      // phase 0: reset values (also reused after the mid-period reset)
      vq.push_back('{"rst_period",    0, 1'b0, 2'd0, 32'hFFFF_FFFF, 32'd0});
      vq.push_back('{"rst_high",      0, 1'b0, 2'd1, 32'hFFFF_FFFF, 32'd0});
      vq.push_back('{"rst_status",    0, 1'b0, 2'd2, 32'hFFFF_FFFF, 32'd0});
      vq.push_back('{"rst_timeout",   0, 1'b0, 2'd3, 32'hFFFF_FFFF, 32'd50_000_000});
      vq.push_back('{"rst_status8",   0, 1'b1, 2'd2, 32'hFFFF_FFFF, 32'd0});
      vq.push_back('{"rst_timeout8",  0, 1'b1, 2'd3, 32'hFFFF_FFFF, 32'd0});
      // phase 1: 1000-cycle period, 250 high, dir 1
      vq.push_back('{"p1000_period",  1, 1'b0, 2'd0, 32'hFFFF_FFFF, 32'd1000});
      vq.push_back('{"p1000_high",    1, 1'b0, 2'd1, 32'hFFFF_FFFF, 32'd250});
      vq.push_back('{"p1000_status",  1, 1'b0, 2'd2, 32'hFFFF_FFFF, 32'h3});
      // phase 2: 300-cycle period, 100 high, TIMEOUT 500
      vq.push_back('{"p300_timeout",  2, 1'b0, 2'd3, 32'hFFFF_FFFF, 32'd500});
      vq.push_back('{"p300_period",   2, 1'b0, 2'd0, 32'hFFFF_FFFF, 32'd300});
      vq.push_back('{"p300_high",     2, 1'b0, 2'd1, 32'hFFFF_FFFF, 32'd100});
      vq.push_back('{"p300_status",   2, 1'b0, 2'd2, 32'hFFFF_FFFF, 32'h3});

      reset_n   = 1'b0;
      address   = 2'd0;
      read      = 1'b0;
      write     = 1'b0;
      read8     = 1'b0;
      write8    = 1'b0;
      writedata = 32'd0;
      dir_in    = 1'b1;
      hold(1'b0);

      repeat (3) @(posedge clk);
      #1;
      check("rst_readdata",  readdata,  32'd0);
      check("rst_readdata8", readdata8, 32'd0);
      reset_n = 1'b1;
      apply_phase(0);

      // Normal measurement and W1C of VALID
      start_gen(1000, 250);
      repeat (3500) @(posedge clk);
      apply_phase(1);
      bus_write(1'b0, 2'd2, 32'h1);
      bus_read(1'b0, 2'd2, rd);
      check("w1c_valid", rd, 32'h2);

      // Timeout with input stopped low after a full 300-cycle period
      bus_write(1'b0, 2'd3, 32'd500);
      start_gen(300, 100);
      repeat (1200) @(posedge clk);
      apply_phase(2);
      wait_pwm_rise();
      repeat (100) @(posedge clk);
      #3;
      hold(1'b0);
      repeat (370) @(posedge clk);
      bus_read(1'b0, 2'd2, rd);
      check("tmo_before_limit", rd, 32'h3);
      repeat (40) @(posedge clk);
      bus_read(1'b0, 2'd2, rd);
      check("tmo_after_limit", rd, 32'h7);
      bus_read(1'b0, 2'd0, rd);
      check("tmo_period_kept", rd, 32'd300);

      // Restart clears TMO on the next commit
      bus_write(1'b0, 2'd2, 32'h1);
      bus_read(1'b0, 2'd2, rd);
      check("tmo_valid_cleared", rd, 32'h6);
      start_gen(300, 100);
      repeat (800) @(posedge clk);
      bus_read(1'b0, 2'd2, rd);
      check("restart_clears_tmo", rd, 32'h3);

      // 100 % duty: TMO, no commit
      wait_pwm_rise();
      #0;
      hold(1'b1);
      repeat (5) @(posedge clk);
      bus_write(1'b0, 2'd2, 32'h1);
      repeat (700) @(posedge clk);
      bus_read(1'b0, 2'd2, rd);
      check("duty100_status", rd, 32'h6);
      bus_read(1'b0, 2'd0, rd);
      check("duty100_period", rd, 32'd300);
      bus_read(1'b0, 2'd1, rd);
      check("duty100_high", rd, 32'd100);

      // 0 % duty: TMO, no commit
      start_gen(300, 100);
      repeat (800) @(posedge clk);
      wait_pwm_rise();
      repeat (100) @(posedge clk);
      #3;
      hold(1'b0);
      repeat (5) @(posedge clk);
      bus_write(1'b0, 2'd2, 32'h5);
      bus_read(1'b0, 2'd2, rd);
      check("duty0_cleared", rd, 32'h2);
      repeat (700) @(posedge clk);
      bus_read(1'b0, 2'd2, rd);
      check("duty0_status", rd, 32'h6);
      bus_read(1'b0, 2'd0, rd);
      check("duty0_period", rd, 32'd300);

      // W1C of VALID in the same cycle as a commit: set wins
      start_gen(300, 100);
      repeat (800) @(posedge clk);
      wait_pwm_rise();
      @(posedge clk);
      bus_write(1'b0, 2'd2, 32'h1);
      bus_read(1'b0, 2'd2, rd);
      check("w1c_vs_commit", rd, 32'h3);
      bus_write(1'b0, 2'd2, 32'h1);
      bus_read(1'b0, 2'd2, rd);
      check("w1c_mid_period", rd, 32'h2);

      // Direction sampled at commit
      dir_in = 1'b0;
      repeat (700) @(posedge clk);
      bus_read(1'b0, 2'd2, rd);
      check("dir_low", rd, 32'h1);

      // Asynchronous reset mid-period
      wait_pwm_rise();
      repeat (50) @(posedge clk);
      #4;
      reset_n = 1'b0;
      #1;
      check("async_rst_readdata", readdata, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      apply_phase(0);

      // 8-bit instance: saturation and OVF
      hold(1'b0);
      repeat (300) @(posedge clk);
      bus_write(1'b1, 2'd2, 32'h8);
      bus_read(1'b1, 2'd2, rd);
      check("ovf8_pre_clear", rd & 32'h8, 32'h0);
      @(posedge clk);
      #3;
      gen_level = 1'b1;
      repeat (20) @(posedge clk);
      #3;
      gen_level = 1'b0;
      repeat (100) @(posedge clk);
      bus_read(1'b1, 2'd2, rd);
      check("ovf8_not_yet", rd & 32'h8, 32'h0);
      repeat (300) @(posedge clk);
      bus_read(1'b1, 2'd2, rd);
      check("ovf8_set", rd & 32'h8, 32'h8);
      @(posedge clk);
      #3;
      gen_level = 1'b1;
      repeat (20) @(posedge clk);
      #3;
      gen_level = 1'b0;
      repeat (10) @(posedge clk);
      bus_read(1'b1, 2'd0, rd);
      check("pcnt8_saturated", rd, 32'd255);
      bus_read(1'b1, 2'd1, rd);
      check("high8", rd, 32'd20);
      bus_write(1'b1, 2'd2, 32'h8);
      bus_read(1'b1, 2'd2, rd);
      check("ovf8_w1c", rd & 32'h8, 32'h0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Avalon-MM slave peripheral that measures an incoming PWM waveform and its direction line, the receive-side counterpart of the `pwm_gen` motor-drive output. It counts, in `clk` cycles, the period and high time of `pwm_in`, commits both as a coherent pair once per full period, and samples `dir_in` at each rising edge. It sits on the HPS lightweight bridge and is used as a loop-back or feedback monitor for the drive-system PWM and direction conduits.

## Interface
- `CNT_W`, 32: width of period/high counters and registers (≤ 32).
- `DEF_TIMEOUT`, 50_000_000: reset value of the TIMEOUT register, in cycles; 0 disables timeout.

- `clk`  in  1  system clock; all logic on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `address`  in  2  Avalon word address.
- `read`  in  1  Avalon read strobe.
- `write`  in  1  Avalon write strobe.
- `writedata`  in  32  Avalon write data.
- `readdata`  out  32  Avalon read data; fixed read latency 1.
- `pwm_in`  in  1  PWM signal, asynchronous to `clk`.
- `dir_in`  in  1  direction signal, asynchronous to `clk`.

## Operation
- Input path: `pwm_in` and `dir_in` each pass through a 2-flop synchronizer (s1, s2). A third flop s3 holds the previous s2. `rise = s2 & ~s3`, `fall = ~s2 & s3`.
- `pcnt` (CNT_W): on `rise`, load 1. Otherwise, increment, saturating at all-ones. On reaching all-ones, set sticky OVF.
- FSM states:
  - IDLE: wait for the first `rise`, then go to HIGH. Partial periods are discarded.
  - HIGH: on `fall`, `hpend <= pcnt`, go to LOW.
  - LOW: on `rise`, commit `PERIOD <= pcnt`, `HIGH <= hpend`, `DIR <= dir s2`, set VALID, go to HIGH.
- Timeout: in HIGH or LOW, if TIMEOUT ≠ 0 and `pcnt >= TIMEOUT`, set sticky TMO and go to IDLE. PERIOD and HIGH keep their last values. Covers 0 % and 100 % duty and a stopped generator.
- TMO clears automatically on the next committed measurement.
- Register map (word addresses):
  - 0 PERIOD: RO.
  - 1 HIGH: RO.
  - 2 STATUS: bit0 VALID, bit1 DIR, bit2 TMO, bit3 OVF, other bits 0. Writing 1 to bit0, bit2 or bit3 clears that bit (W1C). Bit1 is RO.
  - 3 TIMEOUT: RW, CNT_W bits.
- Registers narrower than 32 bits are zero-extended on read. Writes to RO addresses are ignored.
- If a W1C clear and a hardware set of the same bit occur in the same cycle, the set wins.
- PERIOD and HIGH are only ever updated together, in one cycle, so any read pair taken between two commits is coherent.
- Writing TIMEOUT takes effect on the next cycle's comparison. Writing a TIMEOUT value below the current `pcnt` trips TMO on the next cycle.

## Timing
- Reset (async assert; deassert sampled on `clk`):
  - `readdata`=0, PERIOD=0, HIGH=0, STATUS=0, TIMEOUT=DEF_TIMEOUT.
  - FSM in IDLE, `pcnt`=0, `hpend`=0, synchronizer flops 0.
- Reset mid-measurement discards all progress. The first commit after reset needs one full period following the first observed rise.
- Edge latency: a `pwm_in` transition sampled at clock edge k appears as `rise`/`fall` in the cycle after edge k+1. The committed register is visible from edge k+2.
- PERIOD equals the exact cycle count between successive sampled rises; HIGH equals the cycle count from rise to fall. Synchronizer jitter is ±1 cycle per edge.
- Read: `read` asserted at edge n → `readdata` valid after edge n+1. `readdata` holds its value when `read` is low.
- Write: takes effect at the edge where `write` is sampled.
- Minimum measurable high or low time: 2 cycles. Shorter pulses may be missed without error.

## Test plan
- Reset, then read all four addresses → 0, 0, 0x0, 50_000_000.
- `pwm_in` with 1000-cycle period, 250 high, `dir_in`=1, run 3 periods → PERIOD=1000, HIGH=250, STATUS=0x3. Write 0x1 to STATUS → STATUS=0x2.
- TIMEOUT=500; stop `pwm_in` low after a valid 300-cycle period → TMO set ~500 cycles after the last rise, PERIOD still 300. Restart with a 300-cycle period → after two rises TMO=0, VALID=1.
- `pwm_in` held high (100 % duty) with TIMEOUT=500 → TMO=1, VALID unchanged, no commit. Same result for 0 % duty.
- CNT_W=8, TIMEOUT=0, `pwm_in` idle > 255 cycles after a rise → OVF=1, `pcnt` saturates at 255. Write 0x8 to STATUS → OVF cleared.
- Same-cycle W1C of VALID and a commit → VALID reads 1. Assert `reset_n` low mid-period → all outputs return to reset values immediately.
